seg7_scan_controller: RTL and testbench
=======================================

# seg7_scan_controller

Time-multiplexed scan controller for an N-digit common-anode 7-segment display built around one shared BCD-to-7-segment converter. It holds a frame of BCD digits and selects one digit at a time. For each digit it drives the 4-bit code to the converter and enables that digit's anode. A guard interval between digits prevents ghosting. New frames are committed only at frame boundaries, so the display never shows a torn frame.

## Interface
- `N_DIGITS`, 4: number of digits; index 0 is least significant; range 2..8.
- `DIV`, 50000: SHOW dwell per digit in clk cycles; must be ≥ 1.
- `GUARD`, 16: all-anodes-off cycles before each digit; 0 disables the guard.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: scanning enabled; low forces display dark.
- `load` in 1: single-cycle strobe; captures `digits_in`/`dp_in` into shadow.
- `digits_in` in 4*N_DIGITS: BCD digits; digit k occupies bits [4k+3:4k].
- `dp_in` in N_DIGITS: decimal point per digit, active-high.
- `bcd_out` out 4: code to converter inputs {w3,w2,w1,w0}; 4'hF = blank (converter maps it to all-off).
- `an` out N_DIGITS: anode enables, active-low; one-hot-low or all ones.
- `dp_out` out 1: decimal point of the displayed digit, active-high.
- `frame_done` out 1: one-cycle pulse at the end of each complete scan.

## Operation
- Registers:
  - shadow frame + `pending` flag.
  - display frame.
  - digit index `idx` (clog2(N_DIGITS) bits).
  - dwell counter (wide enough for max(DIV, GUARD)).
  - state.
- States:
  - IDLE → GUARD when `enable` = 1; `idx` ← 0.
  - GUARD → SHOW after GUARD cycles; with GUARD = 0, go straight to SHOW.
  - SHOW → GUARD after DIV cycles, with `idx` ← `idx`+1, wrapping N_DIGITS-1 → 0.
  - Any state → IDLE when `enable` = 0; `enable` has priority over every other transition.
- GUARD outputs: `an` all ones; `bcd_out` = display digit[idx]; `dp_out` = 0.
- SHOW outputs: `an[idx]` = 0, all others 1; `bcd_out` = display digit[idx]; `dp_out` = display dp[idx].
- IDLE outputs: `an` all ones, `bcd_out` = 4'hF, `dp_out` = 0.
- Load:
  - `load` = 1 writes shadow and sets `pending`.
  - A second load before commit overwrites the first (newest wins).
  - `load` is accepted in every state, including IDLE.
- Commit:
  - Happens on the SHOW exit edge of digit N_DIGITS-1.
  - If `pending`, then display ← shadow and `pending` ← 0.
  - `frame_done` pulses in the same cycle.
  - Load and commit in the same cycle: the commit uses the old shadow; the new data stays pending for the next frame.
- Commit from IDLE: while IDLE, a pending frame commits on the IDLE→GUARD transition. A dark display has no tearing hazard.
- Digit codes 4'hA–4'hE are passed through unmodified; the converter renders them blank.

## Timing
- Reset values (asynchronous):
  - `an` = all ones; `bcd_out` = 4'hF; `dp_out` = 0; `frame_done` = 0.
  - State IDLE; `idx` = 0; counter = 0; `pending` = 0.
  - Display and shadow frames = all 4'hF; dp = 0.
- All outputs are registered, so a state change appears on outputs at the next clk edge.
- Frame period = N_DIGITS × (GUARD + DIV) cycles.
- With defaults (N_DIGITS=4, GUARD=16, DIV=50000): frame = 200064 cycles; `frame_done` every 200064 cycles.
- `enable` falling edge: `an` is all ones one cycle later. A partial frame gives no `frame_done` and no commit.
- Reset mid-frame: outputs return to their reset values immediately; shadow, display and pending data are lost.
- Load latency to visible: at most one frame period plus GUARD + DIV cycles after `load`.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking is enabled.
  - A digit is blanked when its value is 0, every more-significant digit is 0, and its index is not 0.
  - For a blanked digit, SHOW drives `bcd_out` = 4'hF and keeps `an` all ones.
  - `dp_out` follows dp[idx]; if dp is set, the digit is not blanked and neither is any less-significant digit.
  - Timing and `frame_done` are unchanged.
- `SEG7_LZB_EN` undefined: all digits are shown as stored; a zero displays as "0".

## Test plan
1. Reset held, then released with `enable` = 0. Expect `an` = 4'b1111, `bcd_out` = 4'hF, `frame_done` never pulses.
2. Use DIV=4, GUARD=2. Load 16'h1234 with dp=4'b0100, then set `enable` = 1.
   - Each digit: 2 cycles `an` = 1111, then 4 cycles with `an` = 1110/1101/1011/0111.
   - `bcd_out` sequence 4,3,2,1.
   - `dp_out` = 1 only while `an` = 1011.
   - `frame_done` pulses every 24 cycles.
3. With the scan running on 16'h1234, load 16'h5678 while digit 1 is in SHOW.
   - The remaining digits of the current frame still show 2,1.
   - The next frame shows 8,7,6,5.
   - Two loads (16'h1111 then 16'h9999) in one frame: only 16'h9999 ever appears.
4. Drop `enable` mid-SHOW of digit 2. Expect `an` = 1111 on the next cycle and no `frame_done`. Re-enabling restarts at digit 0 after GUARD.
5. Load 16'h0070 with `SEG7_LZB_EN` defined: digits 3 and 2 have `an` held high with `bcd_out` = F; digits 1 and 0 show 7 and 0. Without the macro, all four digits light: 0,7,0,0.
6. Assert `rst_n` low mid-SHOW of digit 1. All outputs reach reset values without a clk edge. After release, the display stays blank (4'hF) until a load commits.

Source files
------------

// File: rtl/seg7_scan_controller.sv
// -----------------------------------------------------------------------------
// seg7_scan_controller
//
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display sharing one BCD-to-7-segment converter. Holds a shadow frame
// (written by load) and a display frame (what is being scanned). The shadow
// frame moves into the display frame only at a frame boundary, so a frame is
// never shown torn.
//
// Parameters:
//   N_DIGITS  number of digits (2..8), index 0 least significant
//   DIV       SHOW dwell per digit in clk cycles (>= 1)
//   GUARD     all-anodes-off cycles before each digit (0 = no guard)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       scanning enable; low forces the display dark
//   load         one-cycle strobe capturing digits_in/dp_in into the shadow
//   digits_in    BCD digits, digit k at [4k+3:4k]
//   dp_in        decimal point per digit, active-high
//   bcd_out      code to the converter; 4'hF renders blank
//   an           anode enables, active-low, one-hot-low or all ones
//   dp_out       decimal point of the displayed digit, active-high
//   frame_done   one-cycle pulse when a complete scan ends
//
// Build option:
//   SEG7_LZB_EN  when defined, leading zeros are blanked (digit 0 is never
//                blanked, and a set decimal point stops blanking at and below
//                its digit).
//
// State table:
//   IDLE  | display dark, waiting for enable
//   GUARD | anodes off ahead of the current digit (anti-ghosting)
//   SHOW  | current digit's anode driven for DIV cycles
// -----------------------------------------------------------------------------
module seg7_scan_controller #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int GUARD    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [3:0]              bcd_out,
  output logic [N_DIGITS-1:0]     an,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int IW       = $clog2(N_DIGITS);
  localparam int CNT_MAX  = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int GUARD_M1 = (GUARD > 0) ? GUARD - 1 : 0;

  localparam logic [CW-1:0] DIV_LD   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_M1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GUARDS = 2'd1;
  localparam logic [1:0] SHOW   = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N_DIGITS-1:0][3:0]   shadow_q, shadow_d;
  logic [N_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
  logic                       pending_q, pending_d;
  logic [N_DIGITS-1:0][3:0]   disp_q, disp_d;
  logic [N_DIGITS-1:0]        disp_dp_q, disp_dp_d;

  logic [3:0]                 bcd_q, bcd_d;
  logic [N_DIGITS-1:0]        an_q, an_d;
  logic                       dp_q, dp_d;
  logic                       frame_done_q, frame_done_d;

  // commit: frame boundary where a pending shadow may move to the display
  logic                       commit;
  logic [N_DIGITS-1:0]        blank;
  logic [3:0]                 cur_digit;
  logic                       cur_dp;

  // ---------------------------------------------------------------------------
  // Scan sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    commit       = 1'b0;
    frame_done_d = 1'b0;

    if (!enable) begin
      // enable outranks every other transition; a partial frame neither
      // commits nor signals frame_done
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d  = '0;
          // dark display: no tearing hazard, so a pending frame goes live now
          commit = 1'b1;
          if (GUARD > 0) begin
            state_d = GUARDS;
            cnt_d   = GUARD_LD;
          end else begin
            state_d = SHOW;
            cnt_d   = DIV_LD;
          end
        end

        GUARDS: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
            cnt_d   = DIV_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        SHOW: begin
          if (cnt_q == '0) begin
            if (idx_q == LAST_IDX) begin
              idx_d        = '0;
              commit       = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
            if (GUARD > 0) begin
              state_d = GUARDS;
              cnt_d   = GUARD_LD;
            end else begin
              state_d = SHOW;
              cnt_d   = DIV_LD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / display frames
  // ---------------------------------------------------------------------------
  // A load coinciding with a commit lands in the shadow after the old shadow
  // has been taken, so it stays pending for the following frame.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;

    if (commit && pending_q) begin
      disp_d    = shadow_q;
      disp_dp_d = shadow_dp_q;
      pending_d = 1'b0;
    end

    if (load) begin
      shadow_d    = digits_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking
  // ---------------------------------------------------------------------------
`ifdef SEG7_LZB_EN
  // Walk from the most significant digit down; blanking continues only while
  // every digit so far is zero with no decimal point. Digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (disp_d[k] == 4'h0) && !disp_dp_d[k];
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Decoded from next-state values so the registered outputs line up with the
  // state register.
  assign cur_digit = disp_d[idx_d];
  assign cur_dp    = disp_dp_d[idx_d];

  always_comb begin
    an_d  = '1;
    bcd_d = 4'hF;
    dp_d  = 1'b0;
    case (state_d)
      GUARDS: begin
        bcd_d = cur_digit;
      end
      SHOW: begin
        dp_d = cur_dp;
        if (blank[idx_d]) begin
          bcd_d = 4'hF;
        end else begin
          bcd_d        = cur_digit;
          an_d[idx_d]  = 1'b0;
        end
      end
      default: begin
        an_d  = '1;
        bcd_d = 4'hF;
        dp_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= {N_DIGITS{4'hF}};
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      disp_q       <= {N_DIGITS{4'hF}};
      disp_dp_q    <= '0;
      bcd_q        <= 4'hF;
      an_q         <= '1;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      bcd_q        <= bcd_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign an         = an_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with N_DIGITS=4, DIV=4, GUARD=2
// (one digit slot = 6 cycles, one frame = 24 cycles). Outputs are sampled on
// the falling clock edge; inputs change there too.
module tb_seg7_scan_controller;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = GUARD + DIV;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   digits_in = 16'h0000;
  logic [3:0]    dp_in = 4'h0;
  logic [3:0]    bcd_out;
  logic [3:0]    an;
  logic          dp_out;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_controller #(
    .N_DIGITS(N),
    .DIV     (DIV),
    .GUARD   (GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .bcd_out   (bcd_out),
    .an        (an),
    .dp_out    (dp_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected leading-zero blanking of digit k for a frame.
  function automatic logic blank_exp(input logic [15:0] d, input logic [3:0] p, input int k);
    logic b;
    b = (k != 0);
    for (int j = k; j < N; j++) begin
      if (d[4*j +: 4] != 4'h0 || p[j]) b = 1'b0;
    end
`ifndef SEG7_LZB_EN
    b = 1'b0;
`endif
    return b;
  endfunction

  // Observe ncyc cycles of a frame starting at its first GUARD cycle.
  // Optional loads are issued at cycle indices la1/la2 (-1 = none).
  task automatic run_frame(input string name, input logic [15:0] exp_d, input logic [3:0] exp_p,
                           input bit fd_first, input int ncyc,
                           input int la1, input logic [15:0] lv1,
                           input int la2, input logic [15:0] lv2);
    for (int j = 0; j < ncyc; j++) begin
      int         k;
      int         ph;
      logic [3:0] e_an;
      logic [3:0] e_bcd;
      logic       e_dp;
      @(negedge clk);
      k     = (j % FRAME) / SLOT;
      ph    = j % SLOT;
      e_bcd = exp_d[4*k +: 4];
      e_an  = 4'hF;
      e_dp  = 1'b0;
      if (ph >= GUARD) begin
        e_dp = exp_p[k];
        if (blank_exp(exp_d, exp_p, k)) e_bcd = 4'hF;
        else                            e_an  = ~(4'b0001 << k);
      end
      check($sformatf("%s_an_j%0d", name, j),  {12'h0, an},       {12'h0, e_an});
      check($sformatf("%s_bcd_j%0d", name, j), {12'h0, bcd_out},  {12'h0, e_bcd});
      check($sformatf("%s_dp_j%0d", name, j),  {15'h0, dp_out},   {15'h0, e_dp});
      check($sformatf("%s_fd_j%0d", name, j),  {15'h0, frame_done},
            {15'h0, (j == 0) && fd_first});
      load = (j == la1) || (j == la2);
      if (j == la1) digits_in = lv1;
      if (j == la2) digits_in = lv2;
    end
  endtask

  initial begin
    // Reset held
    #12;
    check("rst_an",  {12'h0, an},         16'h000F);
    check("rst_bcd", {12'h0, bcd_out},    16'h000F);
    check("rst_dp",  {15'h0, dp_out},     16'h0000);
    check("rst_fd",  {15'h0, frame_done}, 16'h0000);

    // Released with enable low: stays dark, no frame_done
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_an_%0d", i),  {12'h0, an},         16'h000F);
      check($sformatf("idle_bcd_%0d", i), {12'h0, bcd_out},    16'h000F);
      check($sformatf("idle_fd_%0d", i),  {15'h0, frame_done}, 16'h0000);
    end

    // Basic scan of 1234 with dp on digit 2
    digits_in = 16'h1234;
    dp_in     = 4'b0100;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    enable    = 1'b1;
    run_frame("f1", 16'h1234, 4'b0100, 1'b0, FRAME, -1, 16'h0, -1, 16'h0);
    run_frame("f2", 16'h1234, 4'b0100, 1'b1, FRAME, -1, 16'h0, -1, 16'h0);

    // Load during digit 1 SHOW: current frame finishes unchanged
    dp_in = 4'b0000;
    run_frame("f3", 16'h1234, 4'b0100, 1'b1, FRAME, 9, 16'h5678, -1, 16'h0);
    // Two loads in one frame: newest wins
    run_frame("f4", 16'h5678, 4'b0000, 1'b1, FRAME, 2, 16'h1111, 14, 16'h9999);
    // Load on the commit edge stays pending for the frame after
    run_frame("f5", 16'h9999, 4'b0000, 1'b1, FRAME, 5, 16'h2222, FRAME - 1, 16'h4321);
    run_frame("f6", 16'h2222, 4'b0000, 1'b1, FRAME, -1, 16'h0, -1, 16'h0);

    // Drop enable in the middle of digit 2 SHOW
    run_frame("f7", 16'h4321, 4'b0000, 1'b1, 16, -1, 16'h0, -1, 16'h0);
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("off_an_%0d", i),  {12'h0, an},         16'h000F);
      check($sformatf("off_bcd_%0d", i), {12'h0, bcd_out},    16'h000F);
      check($sformatf("off_dp_%0d", i),  {15'h0, dp_out},     16'h0000);
      check($sformatf("off_fd_%0d", i),  {15'h0, frame_done}, 16'h0000);
    end
    // Re-enable restarts at digit 0 after the guard
    enable = 1'b1;
    run_frame("f8", 16'h4321, 4'b0000, 1'b0, FRAME, -1, 16'h0, -1, 16'h0);

    // Load while IDLE commits on leaving IDLE; leading zeros
    enable = 1'b0;
    @(negedge clk);
    digits_in = 16'h0070;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    enable    = 1'b1;
    run_frame("f9",  16'h0070, 4'b0000, 1'b0, FRAME, -1, 16'h0, -1, 16'h0);
    run_frame("f10", 16'h0070, 4'b0000, 1'b1, 10, -1, 16'h0, -1, 16'h0);

    // Asynchronous reset in the middle of digit 1 SHOW
    rst_n = 1'b0;
    #1;
    check("arst_an",  {12'h0, an},         16'h000F);
    check("arst_bcd", {12'h0, bcd_out},    16'h000F);
    check("arst_dp",  {15'h0, dp_out},     16'h0000);
    check("arst_fd",  {15'h0, frame_done}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    // Display frame lost: blank until a new load commits
    run_frame("f11", 16'hFFFF, 4'b0000, 1'b0, FRAME, -1, 16'h0, -1, 16'h0);
    run_frame("f12", 16'hFFFF, 4'b0000, 1'b1, FRAME, 3, 16'h0950, -1, 16'h0);
    run_frame("f13", 16'h0950, 4'b0000, 1'b1, FRAME, -1, 16'h0, -1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
